// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int unsigned DEF_DIV_W = 26;
    localparam int unsigned DEF_HALF  = 25_000_000;

    typedef logic [DEF_DIV_W-1:0] div_t;

    // Channel-select width; a single channel still needs a 1-bit select.
    function automatic int unsigned ch_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_clk_divider_if.sv
// Configuration bus of the divider: write strobe, channel select, half-period and pending flags.
interface multi_clk_divider_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = DEF_DIV_W
);

    localparam int unsigned CH_W = ch_w(NUM_CH);

    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] cfg_pending;

    modport master (output cfg_wr, cfg_ch, cfg_half, input cfg_pending);
    modport slave  (input cfg_wr, cfg_ch, cfg_half, output cfg_pending);

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active/pending half-period and clk_out/tick flops.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W        = DEF_DIV_W,
    parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [DIV_W-1:0] half,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W-1:0] wr_val;
    logic             at_end;
    logic             fall;

    always_comb begin
        wr_val = (half == '0) ? ONE : half;
        at_end = (cnt == active - ONE);
        fall   = en && at_end && clk_out;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            pending  <= 1'b0;
            active   <= DIV_W'(DEFAULT_HALF);
            pend_val <= '0;
        end else if (sync) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (wr)
                active <= wr_val;
            else if (pending)
                active <= pend_val;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (at_end) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                    tick    <= ~clk_out;
                end else begin
                    cnt <= cnt + ONE;
                end
            end
            // Swap only on the falling toggle; a write in that same cycle queues behind it.
            if (fall && pending) begin
                active  <= pend_val;
                pending <= 1'b0;
            end
            if (wr) begin
                pend_val <= wr_val;
                pending  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_clk_divider.sv
// NUM_CH programmable square-wave / tick dividers from one fast clock with global phase sync.
module multi_clk_divider
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DIV_W        = DEF_DIV_W,
    parameter int unsigned DEFAULT_HALF = DEF_HALF
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync,
    multi_clk_divider_if.slave  cfg,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick
);

    localparam int unsigned CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0] wr_stb;
    logic [NUM_CH-1:0] pend;

    // Out-of-range channel numbers match no strobe, so such writes are dropped.
    always_comb begin
        wr_stb = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i)))
                wr_stb[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .DIV_W        (DIV_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (ch_en[g]),
            .sync    (sync),
            .wr      (wr_stb[g]),
            .half    (cfg.cfg_half),
            .pending (pend[g]),
            .clk_out (clk_out[g]),
            .tick    (tick[g])
        );
    end

    assign cfg.cfg_pending = pend;

endmodule
